// File: rtl/gpu_pkg.sv
// Shared constants and types for the pixel writer: screen geometry defaults,
// the pending-write entry and the write-port state machine encoding.
package gpu_pkg;

  localparam int DEF_SCREEN_WIDTH  = 640;
  localparam int DEF_SCREEN_HEIGHT = 480;
  localparam int DEF_WIDTH_BITS    = $clog2(DEF_SCREEN_WIDTH);
  localparam int DEF_HEIGHT_BITS   = $clog2(DEF_SCREEN_HEIGHT);
  localparam int DEF_ADDR_BITS     = 19;
  localparam int DEF_COLOR_BITS    = 24;
  localparam int DEF_FIFO_DEPTH    = 4;

  typedef struct packed {
    logic [DEF_ADDR_BITS-1:0]  addr;
    logic [DEF_COLOR_BITS-1:0] color;
  } pix_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/gpu_pixel_fifo.sv
// Small synchronous FIFO of pending framebuffer writes; head entry is visible
// combinationally so the write port can hold it stable until acknowledged.
import gpu_pkg::*;

module gpu_pixel_fifo #(
  parameter  int DEPTH    = DEF_FIFO_DEPTH,
  localparam int PTR_BITS = $clog2(DEPTH),
  localparam int CNT_BITS = PTR_BITS + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  pix_entry_t          data_i,
  input  logic                pop_i,
  output pix_entry_t          head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CNT_BITS-1:0] count_o
);

  pix_entry_t          mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until count says it was written.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_BITS'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  no_push_when_full: assert property (@(posedge clk) disable iff (rst) push_i |-> !full_o);

endmodule

// File: rtl/gpu_pixel_writer.sv
// Clips rasteriser pixels, converts them to linear framebuffer addresses and
// issues req/ack writes. Optional counters: define GPU_PIXEL_WRITER_STATS_EN.
import gpu_pkg::*;

module gpu_pixel_writer #(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int COLOR_BITS    = DEF_COLOR_BITS,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int WIDTH_BITS    = $clog2(SCREEN_WIDTH),
  parameter int HEIGHT_BITS   = $clog2(SCREEN_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH_BITS-1:0]  x_i,
  input  logic [HEIGHT_BITS-1:0] y_i,
  input  logic [COLOR_BITS-1:0]  color_i,
  input  logic                   valid_i,
  input  logic                   done_i,
  output logic                   stall_o,
  output logic [ADDR_BITS-1:0]   mem_addr_o,
  output logic [COLOR_BITS-1:0]  mem_data_o,
  output logic                   mem_wr_o,
  input  logic                   mem_ack_i,
  output logic                   busy_o,
  output logic                   done_o
`ifdef GPU_PIXEL_WRITER_STATS_EN
  ,
  output logic [15:0]            pix_written_o,
  output logic [15:0]            pix_clipped_o
`endif
);

  localparam int CNT_BITS = $clog2(FIFO_DEPTH) + 1;

  wr_state_t           state_q, state_d;
  pix_entry_t          stage_q, stage_d;
  logic                stage_valid_q, stage_valid_d;
  logic                done_pend_q, done_pend_d;
  logic                go_done;
  logic                accept, clipped;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_BITS-1:0] fifo_count;
  pix_entry_t          fifo_head;

  assign clipped = (int'(x_i) >= SCREEN_WIDTH) || (int'(y_i) >= SCREEN_HEIGHT);
  // Stall looks one entry ahead because the stage register pushes a cycle after accept.
  assign stall_o = fifo_full || ((fifo_count == CNT_BITS'(FIFO_DEPTH - 1)) && stage_valid_q);
  assign accept  = valid_i && !stall_o;

  always_comb begin
    stage_d       = stage_q;
    stage_valid_d = accept && !clipped;
    if (accept) begin
      stage_d.addr  = ADDR_BITS'(y_i) * ADDR_BITS'(SCREEN_WIDTH) + ADDR_BITS'(x_i);
      stage_d.color = color_i;
    end
  end

  assign fifo_push = stage_valid_q;

  gpu_pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (stage_q),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    go_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = WRITE;
        end else if (done_pend_q && !stage_valid_q) begin
          state_d = DONE;
          go_done = 1'b1;
        end
      end
      WRITE: begin
        if (mem_ack_i) begin
          fifo_pop = 1'b1;
          // A push landing in the same cycle keeps the port busy back-to-back.
          if ((fifo_count > CNT_BITS'(1)) || fifo_push) state_d = WRITE;
          else                                          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done_pend_d = done_i || (done_pend_q && !go_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      stage_q       <= '0;
      stage_valid_q <= 1'b0;
      done_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      stage_valid_q <= stage_valid_d;
      done_pend_q   <= done_pend_d;
    end
  end

  assign mem_wr_o   = (state_q == WRITE);
  assign mem_addr_o = mem_wr_o ? ADDR_BITS'(fifo_head.addr)   : '0;
  assign mem_data_o = mem_wr_o ? COLOR_BITS'(fifo_head.color) : '0;
  assign done_o     = (state_q == DONE);
  assign busy_o     = stage_valid_q || !fifo_empty || (state_q != IDLE) || done_pend_q;

`ifdef GPU_PIXEL_WRITER_STATS_EN
  logic [15:0] written_q, clipped_q;

  always_ff @(posedge clk) begin
    if (rst || done_o) begin
      written_q <= '0;
      clipped_q <= '0;
    end else begin
      if (mem_wr_o && mem_ack_i && (written_q != 16'hFFFF)) written_q <= written_q + 16'd1;
      if (accept && clipped && (clipped_q != 16'hFFFF))     clipped_q <= clipped_q + 16'd1;
    end
  end

  assign pix_written_o = written_q;
  assign pix_clipped_o = clipped_q;
`endif

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Scoreboard bench for gpu_pixel_writer: table of pixels with precomputed
// addresses plus raster, clip, reset and done-ordering sequences.
`timescale 1ns/1ps
module tb_gpu_pixel_writer;
  import gpu_pkg::*;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] color;
    bit          done;
    bit          clip;
    int          addr;
  } vec_t;

  typedef struct {
    logic [18:0] addr;
    logic [23:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x_i;
  logic [8:0]  y_i;
  logic [23:0] color_i;
  logic        valid_i, done_i, stall_o;
  logic [18:0] mem_addr_o;
  logic [23:0] mem_data_o;
  logic        mem_wr_o, mem_ack_i, busy_o, done_o;
`ifdef GPU_PIXEL_WRITER_STATS_EN
  logic [15:0] pix_written_o, pix_clipped_o;
`endif

  exp_t expQ[$];
  vec_t tbl[6];
  int   total = 0;
  int   bad = 0;
  int   ackDelay = 0;
  int   waitCnt = 0;
  int   writesSeen = 0;
  int   doneCount = 0;
  bit   sawStall = 0;

  always #5 clk = ~clk;

  gpu_pixel_writer dut (
    .clk        (clk),
    .rst        (rst),
    .x_i        (x_i),
    .y_i        (y_i),
    .color_i    (color_i),
    .valid_i    (valid_i),
    .done_i     (done_i),
    .stall_o    (stall_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_wr_o   (mem_wr_o),
    .mem_ack_i  (mem_ack_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
`ifdef GPU_PIXEL_WRITER_STATS_EN
    ,
    .pix_written_o (pix_written_o),
    .pix_clipped_o (pix_clipped_o)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Memory model: acks after ackDelay waiting cycles, checks every presented write against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      mem_ack_i = 1'b0;
      waitCnt   = 0;
    end else begin
      if (done_o) begin
        doneCount++;
        checkOutput("pending writes at done_o", 64'(expQ.size()), 64'd0);
      end
      if (mem_wr_o) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected write: got addr %0d expected no write", mem_addr_o);
          mem_ack_i = 1'b1;
        end else begin
          checkOutput("write addr", 64'(mem_addr_o), 64'(expQ[0].addr));
          checkOutput("write data", 64'(mem_data_o), 64'(expQ[0].data));
          if (waitCnt >= ackDelay) begin
            mem_ack_i = 1'b1;
            void'(expQ.pop_front());
            writesSeen++;
            waitCnt = 0;
          end else begin
            mem_ack_i = 1'b0;
            waitCnt++;
          end
        end
      end else begin
        mem_ack_i = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    bit accepted = 0;
    x_i     = v.x[9:0];
    y_i     = v.y[8:0];
    color_i = v.color;
    done_i  = v.done;
    valid_i = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!stall_o) begin
        if (!v.clip) expQ.push_back('{19'(v.addr), v.color});
        accepted = 1;
        break;
      end
      sawStall = 1;
    end
    if (!accepted) begin
      total++;
      bad++;
      $display("[TB] FAIL accept timeout: got stall for 200 cycles expected accept at (%0d,%0d)", v.x, v.y);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    done_i  = 1'b0;
  endtask

  task automatic pulseDone();
    done_i = 1'b1;
    @(posedge clk);
    #1;
    done_i = 1'b0;
  endtask

  task automatic waitIdle();
    bit idle = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!busy_o && expQ.size() == 0) begin
        idle = 1;
        break;
      end
    end
    if (!idle) begin
      total++;
      bad++;
      $display("[TB] FAIL idle timeout: got busy with %0d queued expected idle", expQ.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int cycles);
    rst     = 1'b1;
    valid_i = 1'b0;
    done_i  = 1'b0;
    expQ.delete();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    checkOutput("reset mem_wr_o", 64'(mem_wr_o), 64'd0);
    checkOutput("reset stall_o", 64'(stall_o), 64'd0);
    checkOutput("reset busy_o", 64'(busy_o), 64'd0);
    checkOutput("reset done_o", 64'(done_o), 64'd0);
    checkOutput("reset mem_addr_o", 64'(mem_addr_o), 64'd0);
    checkOutput("reset mem_data_o", 64'(mem_data_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic vec_t rectPixel(input int x, input int y, input bit done);
    vec_t v;
    v.x     = x;
    v.y     = y;
    v.color = 24'(32'h00A000 + y * 16 + x);
    v.done  = done;
    v.clip  = 0;
    v.addr  = y * 640 + x;
    return v;
  endfunction

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish within 500us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0, d0;
    tbl[0] = '{3,   2,   24'hFFFFFF, 0, 0, 1283};
    tbl[1] = '{0,   0,   24'h123456, 0, 0, 0};
    tbl[2] = '{639, 479, 24'hABCDEF, 0, 0, 307199};
    tbl[3] = '{639, 0,   24'h00FF00, 0, 0, 639};
    tbl[4] = '{0,   1,   24'h0000FF, 0, 0, 640};
    tbl[5] = '{1,   1,   24'hFF0000, 0, 0, 641};

    x_i = '0; y_i = '0; color_i = '0; valid_i = 0; done_i = 0; mem_ack_i = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] reset state");
    doReset(2);

    $display("[TB] single pixel with immediate ack");
    ackDelay = 0;
    w0 = writesSeen; d0 = doneCount;
    applyStimulus(tbl[0]);
    waitIdle();
    checkOutput("single pixel writes", 64'(writesSeen - w0), 64'd1);
    pulseDone();
    waitIdle();
    checkOutput("single pixel done pulses", 64'(doneCount - d0), 64'd1);

    $display("[TB] table of pixels");
    ackDelay = 1;
    w0 = writesSeen; d0 = doneCount;
    for (int i = 0; i < 6; i++) applyStimulus(tbl[i]);
    pulseDone();
    waitIdle();
    checkOutput("table writes", 64'(writesSeen - w0), 64'd6);
    checkOutput("table done pulses", 64'(doneCount - d0), 64'd1);

    $display("[TB] rectangle with slow ack");
    ackDelay = 3;
    sawStall = 0;
    w0 = writesSeen; d0 = doneCount;
    for (int y = 0; y <= 6; y++)
      for (int x = 0; x <= 5; x++)
        applyStimulus(rectPixel(x, y, (x == 5 && y == 6)));
    waitIdle();
    checkOutput("rectangle writes", 64'(writesSeen - w0), 64'd42);
    checkOutput("rectangle done pulses", 64'(doneCount - d0), 64'd1);
    checkOutput("rectangle stall seen", 64'(sawStall), 64'd1);

    $display("[TB] clipped pixels");
    ackDelay = 0;
    w0 = writesSeen; d0 = doneCount;
    applyStimulus('{640, 0, 24'h111111, 0, 1, 0});
    applyStimulus('{0, 480, 24'h222222, 0, 1, 0});
    repeat (2) @(posedge clk);
    #1;
`ifdef GPU_PIXEL_WRITER_STATS_EN
    checkOutput("clipped counter", 64'(pix_clipped_o), 64'd2);
`endif
    checkOutput("clipped busy_o", 64'(busy_o), 64'd0);
    pulseDone();
    waitIdle();
    checkOutput("clipped writes", 64'(writesSeen - w0), 64'd0);
    checkOutput("clipped done pulses", 64'(doneCount - d0), 64'd1);

    $display("[TB] reset mid-stream");
    ackDelay = 3;
    for (int i = 0; i < 10; i++) applyStimulus(rectPixel(i % 6, i / 6, 0));
    doReset(1);
    w0 = writesSeen; d0 = doneCount;
    applyStimulus(tbl[5]);
    pulseDone();
    waitIdle();
    checkOutput("post-reset writes", 64'(writesSeen - w0), 64'd1);
    checkOutput("post-reset done pulses", 64'(doneCount - d0), 64'd1);

    $display("[TB] done with last pixel");
    ackDelay = 2;
    w0 = writesSeen; d0 = doneCount;
    applyStimulus(rectPixel(4, 6, 0));
    applyStimulus(rectPixel(5, 6, 1));
    waitIdle();
    checkOutput("last-pixel writes", 64'(writesSeen - w0), 64'd2);
    checkOutput("last-pixel done pulses", 64'(doneCount - d0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
